lcd_pattern_sched: RTL and testbench



---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/lcd_pattern_sched.sv | 180 ++++++++++++++++++
 tb/tb_lcd_pattern_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD test-pattern scheduler:
//   state_e   - scheduler FSM states
//   PWM_BITS  - width of the backlight duty / PWM counter
//   DUTY_MAX  - full-brightness duty (backlight forced solidly on)
//   duty_up   - saturating duty increment (clamps at DUTY_MAX)
//   duty_down - saturating duty decrement (clamps at 0)
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_FADE_IN  = 3'd1,
    ST_SHOW     = 3'd2,
    ST_FADE_OUT = 3'd3,
    ST_SWITCH   = 3'd4
  } state_e;

  localparam int                  PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = 8'hFF;

  // One extra bit of headroom catches the carry, so the fade-in lands
  // exactly on DUTY_MAX instead of wrapping.
  function automatic logic [PWM_BITS-1:0] duty_up(
    input logic [PWM_BITS-1:0] duty,
    input logic [PWM_BITS-1:0] step
  );
    logic [PWM_BITS:0] sum;
    sum = {1'b0, duty} + {1'b0, step};
    return sum[PWM_BITS] ? DUTY_MAX : sum[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] duty_down(
    input logic [PWM_BITS-1:0] duty,
    input logic [PWM_BITS-1:0] step
  );
    return (duty > step) ? (duty - step) : '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions a raw mechanical push button: two-flop synchroniser, then a
// stability counter that restarts on every change of the synchronised
// level. The debounced level follows only after the input has held still
// long enough. A one-cycle pulse is emitted on each debounced 0->1 edge.
//
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous, active-high reset
//   i_btn  - raw asynchronous button, active-high
//   o_rise - one-cycle pulse on a debounced press
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 400000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       r_sync;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;

  // Two-flop synchroniser: the button is asynchronous to the pixel clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  // Any change of the synchronised level restarts the count; the debounced
  // level is only updated once the count has run out without a change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync[1] != r_last) begin
      r_last <= r_sync[1];
      r_cnt  <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_last;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/lcd_pattern_sched.sv
// ---------------------------------------------------------------------------
// lcd_pattern_sched
// Frame-synchronous scheduler for the RGB LCD test-pattern datapath. Picks
// which pattern generator drives the panel and owns the backlight PWM.
// Pattern changes are hidden behind a backlight fade-out / fade-in and only
// happen on a frame tick while the backlight is fully dark.
//
// Ports:
//   i_clk       - pixel clock (shared with the LCD timing controller)
//   i_rst       - asynchronous, active-high reset
//   i_lcd_vsync - vertical sync from the timing controller, clk-synchronous
//   i_btn_next  - raw push button, active-high, requests the next pattern
//   i_auto_en   - 1 = advance automatically every FRAMES_PER_PAT frames
//   o_pat_sel   - pattern index to the data mux
//   o_lcd_bl    - backlight PWM
//   o_busy      - high whenever the scheduler is not in SHOW
// ---------------------------------------------------------------------------
module lcd_pattern_sched
  import lcd_pkg::*;
#(
  parameter int NUM_PAT        = 8,
  parameter int BOOT_FRAMES    = 4,
  parameter int FRAMES_PER_PAT = 120,
  parameter int FADE_STEP      = 16,
  parameter int DEBOUNCE_CYC   = 400000,
  parameter int VS_ACTIVE_LOW  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_lcd_vsync,
  input  logic                       i_btn_next,
  input  logic                       i_auto_en,
  output logic [$clog2(NUM_PAT)-1:0] o_pat_sel,
  output logic                       o_lcd_bl,
  output logic                       o_busy
);

  localparam int PAT_W   = $clog2(NUM_PAT);
  localparam int BOOT_W  = $clog2(BOOT_FRAMES + 1);
  localparam int FRAME_W = $clog2(FRAMES_PER_PAT + 1);

  localparam logic [PAT_W-1:0]    PAT_LAST   = PAT_W'(NUM_PAT - 1);
  localparam logic [BOOT_W-1:0]   BOOT_LAST  = BOOT_W'(BOOT_FRAMES - 1);
  localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(FRAMES_PER_PAT - 1);
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(FADE_STEP);
  localparam logic                VS_IDLE    = (VS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  state_e              r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic [BOOT_W-1:0]   r_boot_cnt;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [PAT_W-1:0]    r_pat_sel;
  logic                r_pending;
  logic                r_vs_d;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_bl;

  logic                w_vs_edge;
  logic                w_btn_rise;
  logic                w_advance;
  logic                w_consume;
  logic [PWM_BITS-1:0] w_duty_up;
  logic [PWM_BITS-1:0] w_duty_dn;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn_next),
    .o_rise(w_btn_rise)
  );

  // The last-vsync register resets to the idle level so that releasing
  // reset with vsync already idle does not fake a frame start.
  assign w_vs_edge = (VS_ACTIVE_LOW != 0) ? (r_vs_d & ~i_lcd_vsync)
                                          : (~r_vs_d & i_lcd_vsync);

  // Registered edge detect: the frame tick is a one-cycle pulse that follows
  // the vsync edge by one clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vs_d <= VS_IDLE;
      r_tick <= 1'b0;
    end else begin
      r_vs_d <= i_lcd_vsync;
      r_tick <= w_vs_edge;
    end
  end

  assign w_duty_up = duty_up(r_duty, STEP);
  assign w_duty_dn = duty_down(r_duty, STEP);

  // A pending request wins over the auto terminal count; both at once still
  // produce only the single transition into FADE_OUT.
  assign w_advance = r_pending |
                     (i_auto_en & (r_frame_cnt == FRAME_LAST));
  assign w_consume = r_tick & (r_state == ST_SHOW) & w_advance;

  // Button requests latch until SHOW consumes them; further presses while
  // a request is outstanding collapse into it. A press landing in the very
  // cycle of consumption is kept as a fresh request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if (w_btn_rise) begin
      r_pending <= 1'b1;
    end else if (w_consume) begin
      r_pending <= 1'b0;
    end
  end

  // Scheduler FSM. Everything here moves only on a frame tick, so without
  // vsync edges the state and duty freeze. The duty is left untouched on the
  // tick that enters a fade; it starts stepping on the following tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_BOOT;
      r_duty      <= '0;
      r_boot_cnt  <= '0;
      r_frame_cnt <= '0;
      r_pat_sel   <= '0;
    end else if (r_tick) begin
      case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == BOOT_LAST) begin
            r_state <= ST_FADE_IN;
          end else begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
          end
        end
        ST_FADE_IN: begin
          r_duty <= w_duty_up;
          if (w_duty_up == DUTY_MAX) begin
            r_state     <= ST_SHOW;
            r_frame_cnt <= '0;
          end
        end
        ST_SHOW: begin
          if (w_advance) begin
            r_state <= ST_FADE_OUT;
          end else if (i_auto_en) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        ST_FADE_OUT: begin
          r_duty <= w_duty_dn;
          if (w_duty_dn == '0) begin
            r_state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          r_pat_sel <= (r_pat_sel == PAT_LAST) ? '0 : r_pat_sel + 1'b1;
          r_state   <= ST_FADE_IN;
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  // Free-running PWM; full duty is forced solid on so the backlight has no
  // one-in-256 dropout at maximum brightness.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm_cnt <= '0;
      r_bl      <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_bl      <= (r_duty == DUTY_MAX) ? 1'b1 : (r_pwm_cnt < r_duty);
    end
  end

  assign o_pat_sel = r_pat_sel;
  assign o_lcd_bl  = r_bl;
  assign o_busy    = (r_state != ST_SHOW);

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// ---------------------------------------------------------------------------
// tb_lcd_pattern_sched
// Self-checking bench for lcd_pattern_sched with small parameters
// (3 patterns, 2 boot frames, 3 frames per pattern, fade step 64,
// debounce 4 cycles, active-low vsync with a 100-clock frame).
// ---------------------------------------------------------------------------
module tb_lcd_pattern_sched;

  localparam int FRAME_CYC = 100;

  typedef struct {
    int         frames;
    bit         autoEn;
    int         press;    // 0 none, 1 short glitch, 2 one press, 3 two presses
    logic [1:0] expPat;
    logic [7:0] expDuty;
    logic       expBusy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       lcdVsync;
  logic       btnNext;
  logic       autoEn;
  logic [1:0] patSel;
  logic       lcdBl;
  logic       busy;
  logic [7:0] dutyPeek;

  int   total;
  int   bad;
  vec_t vecs[64];
  int   nVec;

  lcd_pattern_sched #(
    .NUM_PAT       (3),
    .BOOT_FRAMES   (2),
    .FRAMES_PER_PAT(3),
    .FADE_STEP     (64),
    .DEBOUNCE_CYC  (4),
    .VS_ACTIVE_LOW (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_lcd_vsync(lcdVsync),
    .i_btn_next (btnNext),
    .i_auto_en  (autoEn),
    .o_pat_sel  (patSel),
    .o_lcd_bl   (lcdBl),
    .o_busy     (busy)
  );

  assign dutyPeek = dut.r_duty;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string what, input int idx,
                          input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s (step %0d): got %0d, want %0d", what, idx, got, want);
    end
  endtask

  task automatic addVec(input int frames, input bit a, input int press,
                        input logic [1:0] pat, input logic [7:0] duty,
                        input logic bsy);
    vecs[nVec] = '{frames, a, press, pat, duty, bsy};
    nVec++;
  endtask

  // One 100-clock frame: vsync low for 4 clocks starting at a falling edge.
  task automatic doFrame();
    @(negedge clk);
    lcdVsync = 1'b0;
    repeat (4) @(negedge clk);
    lcdVsync = 1'b1;
    repeat (FRAME_CYC - 5) @(negedge clk);
  endtask

  task automatic pressBtn(input int holdCyc);
    @(negedge clk);
    btnNext = 1'b1;
    repeat (holdCyc) @(negedge clk);
    btnNext = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic countHigh(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk);
      if (lcdBl) n++;
    end
  endtask

  task automatic applyStimulus(input int idx);
    autoEn = vecs[idx].autoEn;
    case (vecs[idx].press)
      1: pressBtn(3);
      2: pressBtn(10);
      3: begin
        pressBtn(10);
        pressBtn(10);
      end
      default: ;
    endcase
    repeat (vecs[idx].frames) doFrame();
  endtask

  task automatic checkOutput(input int idx);
    checkVal("pat_sel", idx, 32'(patSel), 32'(vecs[idx].expPat));
    checkVal("busy", idx, 32'(busy), 32'(vecs[idx].expBusy));
    checkVal("duty", idx, 32'(dutyPeek), 32'(vecs[idx].expDuty));
    if (vecs[idx].expDuty == 8'hFF)
      checkVal("lcd_bl_full", idx, 32'(lcdBl), 32'd1);
    else if (vecs[idx].expDuty == 8'h00)
      checkVal("lcd_bl_dark", idx, 32'(lcdBl), 32'd0);
  endtask

  task automatic runRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(i);
      checkOutput(i);
    end
  endtask

  initial begin
    int n;
    total    = 0;
    bad      = 0;
    nVec     = 0;
    rst      = 1'b1;
    lcdVsync = 1'b1;
    btnNext  = 1'b0;
    autoEn   = 1'b0;

    // frames, auto, press, pat, duty, busy
    addVec( 1, 0, 0, 0,   0, 1);  // 0  boot tick 1
    addVec( 1, 0, 0, 0,   0, 1);  // 1  boot tick 2 -> FADE_IN
    addVec( 1, 0, 0, 0,  64, 1);  // 2
    addVec( 1, 0, 0, 0, 128, 1);  // 3
    addVec( 1, 0, 0, 0, 192, 1);  // 4
    addVec( 1, 0, 0, 0, 255, 0);  // 5  SHOW
    addVec( 1, 1, 0, 0, 255, 0);  // 6  auto count 1
    addVec( 1, 1, 0, 0, 255, 0);  // 7  auto count 2
    addVec( 1, 1, 0, 0, 255, 1);  // 8  -> FADE_OUT
    addVec( 1, 1, 0, 0, 191, 1);  // 9
    addVec( 1, 1, 0, 0, 127, 1);  // 10
    addVec( 1, 1, 0, 0,  63, 1);  // 11
    addVec( 1, 1, 0, 0,   0, 1);  // 12 -> SWITCH
    addVec( 1, 1, 0, 1,   0, 1);  // 13 pat 1
    addVec( 1, 1, 0, 1,  64, 1);  // 14
    addVec( 1, 1, 0, 1, 128, 1);  // 15
    addVec( 1, 1, 0, 1, 192, 1);  // 16
    addVec( 1, 1, 0, 1, 255, 0);  // 17
    addVec(12, 1, 0, 2, 255, 0);  // 18 full auto cycle to pat 2
    addVec( 8, 1, 0, 0,   0, 1);  // 19 wrap 2 -> 0
    addVec( 4, 1, 0, 0, 255, 0);  // 20
    addVec( 5, 0, 0, 0, 255, 0);  // 21 auto off: hold
    addVec( 2, 0, 1, 0, 255, 0);  // 22 glitch ignored
    addVec( 1, 0, 2, 0, 255, 1);  // 23 press -> FADE_OUT
    addVec( 4, 0, 0, 0,   0, 1);  // 24
    addVec( 1, 0, 0, 1,   0, 1);  // 25
    addVec( 4, 0, 0, 1, 255, 0);  // 26
    addVec( 3, 0, 0, 1, 255, 0);  // 27 exactly one advance
    addVec( 1, 0, 2, 1, 255, 1);  // 28 press -> FADE_OUT
    addVec( 2, 0, 3, 1, 127, 1);  // 29 two presses while fading
    addVec( 2, 0, 0, 1,   0, 1);  // 30
    addVec( 1, 0, 0, 2,   0, 1);  // 31
    addVec( 4, 0, 0, 2, 255, 0);  // 32 SHOW with request pending
    addVec( 1, 0, 0, 2, 255, 1);  // 33 request consumed
    addVec( 9, 0, 0, 0, 255, 0);  // 34
    addVec( 3, 0, 0, 0, 255, 0);  // 35 presses merged into one
    addVec( 2, 1, 0, 0, 255, 0);  // 36 auto count reaches 2
    addVec( 1, 1, 2, 0, 255, 1);  // 37 press + terminal together
    addVec( 9, 1, 0, 1, 255, 0);  // 38 single increment
    addVec( 3, 0, 0, 1, 255, 0);  // 39 nothing stale left
    addVec(10, 1, 0, 2, 128, 1);  // 40 mid fade-in at 128

    $display("[TB] start, %0d vectors", nVec);

    repeat (3) @(negedge clk);
    checkVal("reset_pat_sel", -1, 32'(patSel), 32'd0);
    checkVal("reset_lcd_bl", -1, 32'(lcdBl), 32'd0);
    checkVal("reset_busy", -1, 32'(busy), 32'd1);
    checkVal("reset_duty", -1, 32'(dutyPeek), 32'd0);
    rst = 1'b0;

    // No vsync yet: duty 0 must keep the backlight fully dark.
    countHigh(n);
    checkVal("pwm_duty0_highs", -1, 32'(n), 32'd0);

    runRange(0, 2);
    // Vsync paused: FSM holds at duty 64 while the PWM keeps running.
    countHigh(n);
    checkVal("pwm_duty64_highs", -1, 32'(n), 32'd64);
    countHigh(n);
    checkVal("pwm_duty64_hold", -1, 32'(n), 32'd64);

    runRange(3, 5);
    countHigh(n);
    checkVal("pwm_duty255_highs", -1, 32'(n), 32'd256);

    runRange(6, nVec - 1);

    // Asynchronous reset mid fade-in: outputs must clear before the next edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_rst_lcd_bl", -2, 32'(lcdBl), 32'd0);
    checkVal("async_rst_pat_sel", -2, 32'(patSel), 32'd0);
    checkVal("async_rst_busy", -2, 32'(busy), 32'd1);
    checkVal("async_rst_duty", -2, 32'(dutyPeek), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    autoEn = 1'b0;
    doFrame();
    checkVal("post_rst_busy", -2, 32'(busy), 32'd1);
    checkVal("post_rst_duty", -2, 32'(dutyPeek), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
